board_io_frontend: RTL and testbench

//  Board-side GPIO conditioning between iCE40 pins and the Murax gpioA bus.

---
 rtl/board_io_frontend_pkg.sv | 19 +
 rtl/board_io_frontend_debounce.sv | 66 ++++++
 rtl/board_io_frontend.sv | 95 +++++++++
 tb/tb_board_io_frontend.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_frontend_pkg.sv
// Shared definitions for the board GPIO front end: LED mode encodings and a
// constant-evaluable ceiling log2 used to size the debounce counters.
package board_io_frontend_pkg;

    localparam logic [1:0] LED_MODE_OFF   = 2'b00;
    localparam logic [1:0] LED_MODE_ON    = 2'b01;
    localparam logic [1:0] LED_MODE_PWM   = 2'b10;
    localparam logic [1:0] LED_MODE_BLINK = 2'b11;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/board_io_frontend_debounce.sv
// One button channel: 2-flop synchroniser, polarity normalisation, debounce
// counter and single-cycle press/release pulses aligned with the level update.
module board_io_frontend_debounce
    import board_io_frontend_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int              CNT_W   = clog2_f(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Synchroniser resets to the idle pin level so reset exit never looks like a press.
    localparam logic            PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             pressed_s;
    logic             mismatch_s;
    logic             accept_s;

    // Normalise to pressed = 1 and detect an accepted level change.
    always_comb begin
        pressed_s  = sync2_r ^ PIN_IDLE;
        mismatch_s = (pressed_s != level_r);
        accept_s   = mismatch_s && (cnt_r == CNT_MAX);
    end

    // Synchroniser, debounce counter, debounced level and edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= PIN_IDLE;
            sync2_r   <= PIN_IDLE;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            sync1_r   <= pin;
            sync2_r   <= sync1_r;
            if (!mismatch_s || accept_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            level_r   <= accept_s ? ~level_r : level_r;
            press_r   <= accept_s & ~level_r;
            release_r <= accept_s & level_r;
        end
    end

    assign level         = level_r;
    assign press         = press_r;
    assign release_pulse = release_r;

endmodule

// File: rtl/board_io_frontend.sv
// Board GPIO front end: debounced buttons with sticky press events, and LEDs
// driven per channel as off, on, PWM-dimmed or dimmable blink.
module board_io_frontend
    import board_io_frontend_pkg::*;
#(
    parameter int BTN_COUNT       = 2,
    parameter int LED_COUNT       = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int LED_ACTIVE_LOW  = 0,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int PWM_BITS        = 4,
    parameter int BLINK_DIV_BITS  = 22
) (
    input  logic                          io_mainClk,
    input  logic                          io_reset,
    input  logic [BTN_COUNT-1:0]          btn_pin,
    output logic [BTN_COUNT-1:0]          btn_level,
    output logic [BTN_COUNT-1:0]          btn_press,
    output logic [BTN_COUNT-1:0]          btn_release,
    output logic [BTN_COUNT-1:0]          btn_event,
    input  logic [BTN_COUNT-1:0]          btn_event_clr,
    input  logic [2*LED_COUNT-1:0]        led_mode,
    input  logic [PWM_BITS*LED_COUNT-1:0] led_duty,
    output logic [LED_COUNT-1:0]          led_pin
);

    localparam logic [LED_COUNT-1:0] LED_UNLIT = (LED_ACTIVE_LOW != 0) ? {LED_COUNT{1'b1}} : {LED_COUNT{1'b0}};
    localparam logic [PWM_BITS-1:0]  DUTY_FULL = {PWM_BITS{1'b1}};

    logic [BTN_COUNT-1:0]      event_r;
    logic [PWM_BITS-1:0]       pwm_cnt_r;
    logic [BLINK_DIV_BITS-1:0] blink_div_r;
    logic [LED_COUNT-1:0]      led_pin_r;
    logic [LED_COUNT-1:0]      lit_s;
    logic                      blink_phase_s;

    for (genvar g = 0; g < BTN_COUNT; g++) begin : g_btn
        board_io_frontend_debounce #(
            .ACTIVE_LOW      (BTN_ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk           (io_mainClk),
            .rst           (io_reset),
            .pin           (btn_pin[g]),
            .level         (btn_level[g]),
            .press         (btn_press[g]),
            .release_pulse (btn_release[g])
        );
    end

    // Sticky press flags; a press in the same cycle as a clear keeps the flag set.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            event_r <= '0;
        end else begin
            event_r <= btn_press | (event_r & ~btn_event_clr);
        end
    end

    // Per-LED lit decision from mode, duty and the shared counters.
    always_comb begin
        lit_s         = '0;
        blink_phase_s = blink_div_r[BLINK_DIV_BITS-1];
        for (int i = 0; i < LED_COUNT; i++) begin
            logic [PWM_BITS-1:0] duty;
            logic                pwm_on;
            duty   = led_duty[i*PWM_BITS +: PWM_BITS];
            pwm_on = (duty == DUTY_FULL) ? 1'b1 : (pwm_cnt_r < duty);
            case (led_mode[2*i +: 2])
                LED_MODE_OFF:   lit_s[i] = 1'b0;
                LED_MODE_ON:    lit_s[i] = 1'b1;
                LED_MODE_PWM:   lit_s[i] = pwm_on;
                LED_MODE_BLINK: lit_s[i] = blink_phase_s & pwm_on;
                default:        lit_s[i] = 1'b0;
            endcase
        end
    end

    // Free-running PWM and blink counters plus the registered LED drive.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            pwm_cnt_r   <= '0;
            blink_div_r <= '0;
            led_pin_r   <= LED_UNLIT;
        end else begin
            pwm_cnt_r   <= pwm_cnt_r + PWM_BITS'(1);
            blink_div_r <= blink_div_r + BLINK_DIV_BITS'(1);
            led_pin_r   <= lit_s ^ LED_UNLIT;
        end
    end

    assign btn_event = event_r;
    assign led_pin   = led_pin_r;

endmodule

// File: tb/tb_board_io_frontend.sv
// Self-checking bench for board_io_frontend: directed corner sequences, an LED
// vector table and a randomized run compared against a behavioural model.
module tb_board_io_frontend;

    localparam int NB   = 2;
    localparam int NL   = 2;
    localparam int BAL  = 1;
    localparam int LAL  = 0;
    localparam int DEB  = 4;
    localparam int PWMB = 4;
    localparam int BLKB = 4;
    localparam int PWM_MOD = 1 << PWMB;
    localparam int BLK_MOD = 1 << BLKB;

    logic                 clk;
    logic                 io_reset;
    logic [NB-1:0]        btn_pin;
    logic [NB-1:0]        btn_level;
    logic [NB-1:0]        btn_press;
    logic [NB-1:0]        btn_release;
    logic [NB-1:0]        btn_event;
    logic [NB-1:0]        btn_event_clr;
    logic [2*NL-1:0]      led_mode;
    logic [PWMB*NL-1:0]   led_duty;
    logic [NL-1:0]        led_pin;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [NB-1:0] m_p1, m_p2, m_level, m_press, m_rel, m_ev;
    int            m_run [NB];
    int            m_n;
    logic [NL-1:0] m_led;

    board_io_frontend #(
        .BTN_COUNT(NB), .LED_COUNT(NL), .BTN_ACTIVE_LOW(BAL), .LED_ACTIVE_LOW(LAL),
        .DEBOUNCE_CYCLES(DEB), .PWM_BITS(PWMB), .BLINK_DIV_BITS(BLKB)
    ) dut (
        .io_mainClk(clk), .io_reset(io_reset), .btn_pin(btn_pin),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_event(btn_event), .btn_event_clr(btn_event_clr),
        .led_mode(led_mode), .led_duty(led_duty), .led_pin(led_pin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Spec-level model of one clock edge, using the inputs present at the edge.
    task automatic model_edge();
        logic [NB-1:0] chk;
        logic [NB-1:0] new_ev;
        if (io_reset) begin
            m_p1 = {NB{1'(BAL)}}; m_p2 = {NB{1'(BAL)}};
            m_level = '0; m_press = '0; m_rel = '0; m_ev = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_n = 0;
            m_led = {NL{1'(LAL)}};
        end else begin
            chk    = m_p2 ^ {NB{1'(BAL)}};
            m_p2   = m_p1;
            m_p1   = btn_pin;
            new_ev = m_press | (m_ev & ~btn_event_clr);
            m_press = '0; m_rel = '0;
            for (int i = 0; i < NB; i++) begin
                if (chk[i] != m_level[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) m_press[i] = 1'b1;
                    else m_rel[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
            m_ev = new_ev;
            for (int i = 0; i < NL; i++) begin
                int  pc;
                int  duty;
                bit  ph, pwm_on, lit;
                pc     = m_n % PWM_MOD;
                ph     = (m_n % BLK_MOD) >= (BLK_MOD / 2);
                duty   = int'(led_duty[i*PWMB +: PWMB]);
                pwm_on = (duty == PWM_MOD - 1) || (pc < duty);
                case (led_mode[2*i +: 2])
                    2'b00:   lit = 1'b0;
                    2'b01:   lit = 1'b1;
                    2'b10:   lit = pwm_on;
                    default: lit = ph & pwm_on;
                endcase
                m_led[i] = lit ^ 1'(LAL);
            end
            m_n++;
        end
    endtask

    // Advance one clock, update the model, and compare all outputs off the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_btn_level",   int'(btn_level),   int'(m_level));
        check("model_btn_press",   int'(btn_press),   int'(m_press));
        check("model_btn_release", int'(btn_release), int'(m_rel));
        check("model_btn_event",   int'(btn_event),   int'(m_ev));
        check("model_led_pin",     int'(led_pin),     int'(m_led));
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] duty;
        int         exp_lit;
    } led_vec_t;

    initial begin
        led_vec_t vecs [9];
        int  saw, cnt0, cnt1, pat, exp_pat, hold;
        bit  found;

        vecs[0] = '{2'b00, 4'd9,  0};
        vecs[1] = '{2'b01, 4'd0,  16};
        vecs[2] = '{2'b10, 4'd4,  4};
        vecs[3] = '{2'b10, 4'd0,  0};
        vecs[4] = '{2'b10, 4'd15, 16};
        vecs[5] = '{2'b10, 4'd7,  7};
        vecs[6] = '{2'b11, 4'd15, 8};
        vecs[7] = '{2'b11, 4'd4,  0};
        vecs[8] = '{2'b11, 4'd12, 4};

        io_reset = 1'b1; btn_pin = 2'b11; btn_event_clr = 2'b00;
        led_mode = 4'b0000; led_duty = 8'h00;

        // 1. reset state and clean reset exit
        for (int i = 0; i < 3; i++) step();
        check("reset_level",   int'(btn_level),   0);
        check("reset_press",   int'(btn_press),   0);
        check("reset_release", int'(btn_release), 0);
        check("reset_event",   int'(btn_event),   0);
        check("reset_led_pin", int'(led_pin),     LAL ? 3 : 0);
        io_reset = 1'b0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin step(); saw |= int'(btn_press | btn_release); end
        check("no_pulse_after_reset", saw, 0);

        // 2. stable press: level exactly 6 cycles after the pin edge
        btn_pin[0] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("press_level_cycle5", int'(btn_level[0]), 0);
        step();
        check("press_level_cycle6", int'(btn_level[0]), 1);
        check("press_pulse_high",   int'(btn_press[0]), 1);
        step();
        check("press_pulse_low",    int'(btn_press[0]), 0);
        check("press_event_set",    int'(btn_event[0]), 1);
        for (int i = 0; i < 12; i++) step();
        btn_pin[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("release_level_cycle5", int'(btn_level[0]), 1);
        step();
        check("release_level_cycle6", int'(btn_level[0]), 0);
        check("release_pulse_high",   int'(btn_release[0]), 1);
        btn_event_clr[0] = 1'b1; step(); btn_event_clr[0] = 1'b0;
        check("event_cleared", int'(btn_event[0]), 0);

        // 3. short glitch is ignored
        btn_pin[0] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        btn_pin[0] = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin step(); saw |= int'(btn_level[0] | btn_press[0] | btn_event[0]); end
        check("glitch_ignored", saw, 0);

        // 4. set wins over clear, later lone clear takes effect next cycle
        btn_pin[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin step(); found = btn_press[0]; end
        check("press_seen_within_bound", int'(found), 1);
        btn_event_clr[0] = 1'b1; step(); btn_event_clr[0] = 1'b0;
        check("set_wins_over_clr", int'(btn_event[0]), 1);
        btn_pin[0] = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("event_still_set", int'(btn_event[0]), 1);
        btn_event_clr[0] = 1'b1; step(); btn_event_clr[0] = 1'b0;
        check("lone_clr", int'(btn_event[0]), 0);

        // 5. LED vector table: lit cycles out of 16 for each mode/duty
        foreach (vecs[v]) begin
            led_mode = {vecs[v].mode, vecs[v].mode};
            led_duty = {vecs[v].duty, vecs[v].duty};
            step();
            cnt0 = 0; cnt1 = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                cnt0 += int'(led_pin[0] ^ 1'(LAL));
                cnt1 += int'(led_pin[1] ^ 1'(LAL));
            end
            check($sformatf("led0_lit_count_vec%0d", v), cnt0, vecs[v].exp_lit);
            check($sformatf("led1_lit_count_vec%0d", v), cnt1, vecs[v].exp_lit);
        end

        // 6. blink 8 lit / 8 dark from reset, then reset while lit
        io_reset = 1'b1; step(); step();
        led_mode = 4'b1111; led_duty = 8'hFF;
        io_reset = 1'b0;
        pat = 0; exp_pat = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            pat     |= int'(led_pin[0] ^ 1'(LAL)) << i;
            exp_pat |= (((i % 16) >= 8) ? 1 : 0) << i;
        end
        check("blink_pattern", pat, exp_pat);
        for (int i = 0; i < 10; i++) step();
        check("blink_lit_before_reset", int'(led_pin[0] ^ 1'(LAL)), 1);
        io_reset = 1'b1; step(); io_reset = 1'b0;
        check("blink_reset_unlit", int'(led_pin), LAL ? 3 : 0);

        // Randomized run against the model
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                btn_pin = 2'($urandom_range(0, 3));
                hold    = $urandom_range(1, 10);
            end
            hold--;
            btn_event_clr = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            if ($urandom_range(0, 15) == 0) begin
                led_mode = 4'($urandom);
                led_duty = 8'($urandom);
            end
            io_reset = ($urandom_range(0, 299) == 0);
            step();
        end
        io_reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
